// File: rtl/alu_exec_unit.sv
// Sequential wrapper around the combinational 6502 ALU: one micro-request at a time, committing
// to A, to the flags only, or to memory via a read / dummy-write / write RMW sequence.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_dst,
    input  logic [7:0]  req_operand,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_flag_mask,
    input  logic        a_load,
    input  logic [7:0]  a_load_val,
    input  logic        p_load,
    input  logic [3:0]  p_load_val,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [7:0]  alu_result,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  reg_a,
    output logic        flag_n,
    output logic        flag_v,
    output logic        flag_z,
    output logic        flag_c,
    output logic        done
);

    localparam logic [1:0] DST_ACC   = 2'b00;
    localparam logic [1:0] DST_FLAGS = 2'b01;
    localparam logic [1:0] DST_MEM   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RMW_RD,
        S_RMW_DUMMY,
        S_RMW_WR,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  dst_q;
    logic [3:0]  mask_q;
    logic [7:0]  reg_a_q, reg_a_d;
    logic [3:0]  flags_q, flags_d;      // {N,V,Z,C}
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [3:0]  alu_op_q;
    logic [15:0] mem_addr_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [7:0]  mem_wdata_q;
    logic        done_q;
    logic        req_ready_q;

    logic        accept;
    logic        commit_en;
    logic [3:0]  alu_flags;

    assign accept    = req_valid && req_ready_q && (state_q == S_IDLE);
    assign alu_flags = {alu_n, alu_v, alu_z, alu_c};
    assign commit_en = ((state_q == S_EXEC) && ((dst_q == DST_ACC) || (dst_q == DST_FLAGS)))
                    || (state_q == S_RMW_DUMMY);

    // p_load lands first so that an ALU commit overrides it on the masked bits only.
    always_comb begin
        flags_d = p_load ? p_load_val : flags_q;
        if (commit_en) begin
            flags_d = (flags_d & ~mask_q) | (alu_flags & mask_q);
        end
    end

    always_comb begin
        reg_a_d = reg_a_q;
        if ((state_q == S_IDLE) && a_load) begin
            reg_a_d = a_load_val;
        end else if ((state_q == S_EXEC) && (dst_q == DST_ACC)) begin
            reg_a_d = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            dst_q       <= 2'd0;
            mask_q      <= 4'd0;
            reg_a_q     <= 8'h00;
            flags_q     <= 4'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= 4'd0;
            mem_addr_q  <= 16'h0000;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            reg_a_q <= reg_a_d;
            flags_q <= flags_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= req_op;
                        dst_q       <= req_dst;
                        mask_q      <= req_flag_mask;
                        req_ready_q <= 1'b0;
                        if (req_dst == DST_MEM) begin
                            mem_addr_q <= req_addr;
                            mem_re_q   <= 1'b1;
                            state_q    <= S_RMW_RD;
                        end else begin
                            // A same-cycle a_load must already be visible to EXEC.
                            alu_a_q  <= a_load ? a_load_val : reg_a_q;
                            alu_b_q  <= req_operand;
                            alu_op_q <= req_op;
                            state_q  <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_RMW_RD: begin
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= mem_rdata;
                    alu_a_q     <= mem_rdata;
                    alu_b_q     <= 8'h00;
                    alu_op_q    <= op_q;
                    state_q     <= S_RMW_DUMMY;
                end
                S_RMW_DUMMY: begin
                    mem_wdata_q <= alu_result;
                    state_q     <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    mem_we_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = flags_q[0];
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_a     = reg_a_q;
    assign flag_n    = flags_q[3];
    assign flag_v    = flags_q[2];
    assign flag_z    = flags_q[1];
    assign flag_c    = flags_q[0];
    assign done      = done_q;

endmodule
